// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

    typedef logic [7:0] w8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_t;

    localparam logic REQ_BOOT = 1'b0;
    localparam logic REQ_CORE = 1'b1;

    localparam w8 SDATA_RST = 8'h00;

endpackage

// File: rtl/tx_byte_fifo.sv
// Byte FIFO with extra-MSB pointers; a write while full is ignored.
module tx_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       we,
    input  logic [7:0] wd,
    input  logic       re,
    output logic [7:0] rd,
    output logic       full,
    output logic       empty
);
    import uart_arb_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wptr;
    logic [AW:0] rptr;
    w8           mem [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (we && !full)
                wptr <= wptr + 1'b1;
            if (re && !empty)
                rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (we && !full)
            mem[wptr[AW-1:0]] <= wd;
    end

    assign rd    = mem[rptr[AW-1:0]];
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = (wptr == rptr);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter feeding one UART transmitter.
// Define UART_TX_ARB_RR_EN for round-robin grant; default is fixed boot-first priority.
module uart_tx_arbiter #(
    parameter int FIFO_DEPTH      = 4,
    parameter int TX_BUSY_TIMEOUT = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       boot_en,
    input  logic [7:0] boot_data,
    output logic       boot_busy,
    input  logic       core_en,
    input  logic [7:0] core_data,
    output logic       core_busy,
    output logic       tx_start,
    output logic [7:0] sdata,
    input  logic       tx_busy,
    output logic [1:0] overflow,
    output logic       timeout
);
    import uart_arb_pkg::*;

    localparam int TMO_W = $clog2(TX_BUSY_TIMEOUT) + 1;
    // START counts as the first waiting cycle, so WAIT_BUSY gives up one count early.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TX_BUSY_TIMEOUT - 2);

    arb_state_t       state, state_d;
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_d;
    w8                sdata_q;
    logic [1:0]       overflow_q;
    logic             timeout_q;
    logic             timeout_set;
    logic             grant_boot, grant_core, pick_boot;
    logic             boot_full, boot_empty, core_full, core_empty;
    logic [7:0]       boot_rd, core_rd;

    tx_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_boot_fifo (
        .clock (clock),
        .reset (reset),
        .we    (boot_en),
        .wd    (boot_data),
        .re    (grant_boot),
        .rd    (boot_rd),
        .full  (boot_full),
        .empty (boot_empty)
    );

    tx_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_core_fifo (
        .clock (clock),
        .reset (reset),
        .we    (core_en),
        .wd    (core_data),
        .re    (grant_core),
        .rd    (core_rd),
        .full  (core_full),
        .empty (core_empty)
    );

`ifdef UART_TX_ARB_RR_EN
    logic rr_ptr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            rr_ptr <= REQ_BOOT;
        else if (grant_boot)
            rr_ptr <= REQ_CORE;
        else if (grant_core)
            rr_ptr <= REQ_BOOT;
    end

    assign pick_boot = !boot_empty && (core_empty || rr_ptr == REQ_BOOT);
`else
    assign pick_boot = !boot_empty;
`endif

    always_comb begin
        state_d     = state;
        tmo_cnt_d   = tmo_cnt;
        grant_boot  = 1'b0;
        grant_core  = 1'b0;
        timeout_set = 1'b0;
        case (state)
            IDLE: begin
                tmo_cnt_d = '0;
                if (!tx_busy && (!boot_empty || !core_empty)) begin
                    grant_boot = pick_boot;
                    grant_core = !pick_boot;
                    state_d    = START;
                end
            end
            START: begin
                tmo_cnt_d = '0;
                state_d   = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    timeout_set = 1'b1;
                    state_d     = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            sdata_q    <= SDATA_RST;
            overflow_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state   <= state_d;
            tmo_cnt <= tmo_cnt_d;
            if (grant_boot)
                sdata_q <= boot_rd;
            else if (grant_core)
                sdata_q <= core_rd;
            overflow_q <= overflow_q | {core_en & core_full, boot_en & boot_full};
            timeout_q  <= timeout_q | timeout_set;
        end
    end

    assign tx_start  = (state == START);
    assign sdata     = sdata_q;
    assign boot_busy = boot_full;
    assign core_busy = core_full;
    assign overflow  = overflow_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a byte scoreboard and a UART busy responder.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int FIFO_DEPTH = 4;

    logic       clock, reset;
    logic       boot_en, core_en, boot_busy, core_busy;
    logic [7:0] boot_data, core_data, sdata;
    logic       tx_start, tx_busy, timeout;
    logic [1:0] overflow;

    uart_tx_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .TX_BUSY_TIMEOUT(64)) dut (
        .clock     (clock),
        .reset     (reset),
        .boot_en   (boot_en),
        .boot_data (boot_data),
        .boot_busy (boot_busy),
        .core_en   (core_en),
        .core_data (core_data),
        .core_busy (core_busy),
        .tx_start  (tx_start),
        .sdata     (sdata),
        .tx_busy   (tx_busy),
        .overflow  (overflow),
        .timeout   (timeout)
    );

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         n_starts = 0;
    logic       saw_start = 1'b0;
    logic [7:0] exp_q[$];
    int         busy_mode = 0;   // 0 auto response, 1 held high, 2 held low
    int         busy_len = 3;
    int         busy_left = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // UART model: busy rises the cycle after tx_start and lasts busy_len cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (busy_mode == 1) begin
                tx_busy = 1'b1;
            end else if (busy_mode == 2) begin
                tx_busy = 1'b0;
            end else begin
                if (busy_left > 0) begin
                    tx_busy = 1'b1;
                    busy_left--;
                end else begin
                    tx_busy = 1'b0;
                end
                if (tx_start)
                    busy_left = busy_len;
            end
        end
    end

    task automatic tick();
        logic [7:0] exp;
        @(negedge clock);
        cyc++;
        saw_start = tx_start;
        if (tx_start) begin
            n_starts++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_tx_start: sdata %h with empty scoreboard", sdata);
            end else begin
                exp = exp_q.pop_front();
                if (sdata !== exp) begin
                    errors++;
                    $display("FAIL tx_byte: sdata %h expected %h", sdata, exp);
                end
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            if (dut.state == IDLE && tx_busy === 1'b0 && exp_q.size() == 0) break;
            tick();
        end
        if (k == budget) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: state %0d queue %0d, required IDLE and empty", dut.state, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        boot_en = 1'b0; core_en = 1'b0; boot_data = '0; core_data = '0;
        tick(); tick();
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL rst_tx_start: %b want 0", tx_start); end
        checks++; if (sdata !== 8'h00) begin errors++; $display("FAIL rst_sdata: %h want 00", sdata); end
        checks++; if ({boot_busy, core_busy} !== 2'b00) begin errors++; $display("FAIL rst_busy: %b want 00", {boot_busy, core_busy}); end
        checks++; if (overflow !== 2'b00) begin errors++; $display("FAIL rst_overflow: %b want 00", overflow); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout: %b want 0", timeout); end
        reset = 1'b0;
        tick(); tick();
    endtask

    task automatic test_single();
        int p, s, base, extra;
        logic stable;
        busy_mode = 0; busy_len = 20;
        base = n_starts;
        p = cyc;
        boot_en = 1'b1; boot_data = 8'h41; exp_q.push_back(8'h41);
        tick();
        boot_en = 1'b0;
        for (int k = 0; k < 10 && !saw_start; k++) tick();
        s = cyc;
        checks++; if (s !== p + 2) begin errors++; $display("FAIL single_latency: start at +%0d want +2", s - p); end
        stable = 1'b1;
        extra = 0;
        while (cyc < s + 21) begin
            tick();
            if (saw_start) extra++;
            if (sdata !== 8'h41) stable = 1'b0;
        end
        checks++; if (dut.state !== WAIT_DONE) begin errors++; $display("FAIL single_wait_done: state %0d want %0d", dut.state, WAIT_DONE); end
        tick();
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL single_idle: state %0d want %0d", dut.state, IDLE); end
        checks++; if (!stable) begin errors++; $display("FAIL single_sdata_stable: sdata %h want 41 held", sdata); end
        checks++; if (extra != 0 || n_starts - base != 1) begin errors++; $display("FAIL single_once: starts %0d want 1", n_starts - base); end
        wait_idle(50);
    endtask

    task automatic test_contention();
        int base;
        busy_mode = 0; busy_len = 3;
        base = n_starts;
`ifdef UART_TX_ARB_RR_EN
        exp_q.push_back(8'hAA); exp_q.push_back(8'h01); exp_q.push_back(8'hAB); exp_q.push_back(8'h02);
`else
        exp_q.push_back(8'hAA); exp_q.push_back(8'hAB); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
`endif
        boot_en = 1'b1; core_en = 1'b1; boot_data = 8'hAA; core_data = 8'h01;
        tick();
        boot_data = 8'hAB; core_data = 8'h02;
        tick();
        boot_en = 1'b0; core_en = 1'b0;
        for (int k = 0; k < 200 && n_starts - base < 4; k++) tick();
        checks++; if (n_starts - base != 4) begin errors++; $display("FAIL contention_count: %0d want 4", n_starts - base); end
        wait_idle(50);
    endtask

    task automatic test_overflow();
        int base;
        busy_mode = 1;
        tick(); tick();
        base = n_starts;
        for (int k = 0; k < 6; k++) begin
            core_en = 1'b1; core_data = 8'h10 + 8'(k);
            if (k < 4) exp_q.push_back(8'h10 + 8'(k));
            tick();
            if (k == 2) begin
                checks++; if (core_busy !== 1'b0) begin errors++; $display("FAIL ovf_busy_3: %b want 0", core_busy); end
            end
            if (k == 3) begin
                checks++; if (core_busy !== 1'b1) begin errors++; $display("FAIL ovf_busy_4: %b want 1", core_busy); end
            end
        end
        core_en = 1'b0;
        tick();
        checks++; if (overflow !== 2'b10) begin errors++; $display("FAIL ovf_flag: %b want 10", overflow); end
        checks++; if (boot_busy !== 1'b0) begin errors++; $display("FAIL ovf_boot_busy: %b want 0", boot_busy); end
        busy_mode = 0; busy_len = 3;
        for (int k = 0; k < 200 && n_starts - base < 4; k++) tick();
        for (int k = 0; k < 20; k++) tick();
        checks++; if (n_starts - base != 4) begin errors++; $display("FAIL ovf_count: %0d want 4", n_starts - base); end
        wait_idle(50);
    endtask

    task automatic test_timeout();
        int s;
        busy_mode = 2;
        tick();
        exp_q.push_back(8'h55); exp_q.push_back(8'h66);
        boot_en = 1'b1; boot_data = 8'h55;
        tick();
        boot_data = 8'h66;
        tick();
        boot_en = 1'b0;
        for (int k = 0; k < 10 && !saw_start; k++) tick();
        s = cyc;
        while (cyc < s + 63) tick();
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL tmo_early: %b want 0 at +63", timeout); end
        tick();
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL tmo_set: %b want 1 at +64", timeout); end
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL tmo_idle: state %0d want %0d", dut.state, IDLE); end
        busy_mode = 0; busy_len = 3;
        tick();
        checks++; if (!(saw_start && cyc == s + 65)) begin errors++; $display("FAIL tmo_next: start %b at +%0d want 1 at +65", saw_start, cyc - s); end
        wait_idle(50);
    endtask

    task automatic test_reset_midop();
        int base, k;
        busy_mode = 0; busy_len = 20;
        exp_q.push_back(8'h31);
        for (int i = 0; i < 4; i++) begin
            boot_en = 1'b1; boot_data = 8'h31 + 8'(i);
            tick();
        end
        boot_en = 1'b0;
        for (k = 0; k < 50 && dut.state != WAIT_DONE; k++) tick();
        reset = 1'b1;
        #1;
        checks++;
        if ({tx_start, sdata, boot_busy, core_busy, overflow, timeout} !== 13'h0) begin
            errors++;
            $display("FAIL midop_reset_outputs: %h want 0000", {tx_start, sdata, boot_busy, core_busy, overflow, timeout});
        end
        tick(); tick();
        reset = 1'b0;
        base = n_starts;
        for (int i = 0; i < 30; i++) tick();
        checks++; if (n_starts != base) begin errors++; $display("FAIL midop_no_start: %0d starts want 0", n_starts - base); end
        exp_q.push_back(8'h77);
        boot_en = 1'b1; boot_data = 8'h77;
        tick();
        boot_en = 1'b0;
        for (int i = 0; i < 60 && n_starts == base; i++) tick();
        checks++; if (n_starts - base != 1) begin errors++; $display("FAIL midop_new_push: %0d starts want 1", n_starts - base); end
        wait_idle(50);
    endtask

    task automatic test_wrap();
        int base, pushed, occ, bad, pend;
        busy_mode = 0; busy_len = 2;
        base = n_starts; pushed = 0; occ = 0; bad = 0;
        for (int k = 0; k < 600; k++) begin
            pend = 0;
            if (pushed < 20 && occ < FIFO_DEPTH) begin
                boot_en = 1'b1; boot_data = 8'hC0 + 8'(pushed);
                exp_q.push_back(8'hC0 + 8'(pushed));
                pushed++; pend = 1;
            end else begin
                boot_en = 1'b0;
            end
            tick();
            occ = occ + pend - (saw_start ? 1 : 0);
            if (boot_busy !== (occ == FIFO_DEPTH)) bad++;
            if (n_starts - base == 20) break;
        end
        boot_en = 1'b0;
        checks++; if (n_starts - base != 20) begin errors++; $display("FAIL wrap_count: %0d want 20", n_starts - base); end
        checks++; if (bad != 0) begin errors++; $display("FAIL wrap_full_flag: %0d bad cycles want 0", bad); end
        wait_idle(50);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_leftover: %0d bytes want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_overflow();
        test_timeout();
        test_reset_midop();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: entries per requester FIFO; power of two, >= 2.
REQ-002 SHALL have parameter TX_BUSY_TIMEOUT, default 64: cycles WAIT_BUSY waits for tx_busy before abandoning a byte.
REQ-003 Port clock, input, 1: single clock domain. The block has one clock; reset is asynchronous and active-high.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Ports boot_en, input, 1; boot_data, input, 8; boot_busy, output, 1: boot-loader push pulse, byte, and FIFO-full indicator.
REQ-006 Ports core_en, input, 1; core_data, input, 8; core_busy, output, 1: core push pulse, byte, and FIFO-full indicator.
REQ-007 Ports tx_start, output, 1; sdata, output, 8; tx_busy, input, 1: UART transmitter handshake.
REQ-008 Port overflow, output, 2: sticky drop flags, bit0 boot, bit1 core.
REQ-009 Port timeout, output, 1: sticky flag for an abandoned byte.

Function
REQ-010 Each requester SHALL own one FIFO. On en=1 with FIFO not full, the byte is written at the clock edge.
REQ-011 boot_busy/core_busy SHALL equal the registered FIFO-full state. A push while full SHALL be dropped and set the matching overflow bit, even if a pop happens in the same cycle.
REQ-012 The FSM SHALL have states IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-013 IDLE: if any FIFO is non-empty and tx_busy=0, grant per REQ-020, pop the head into the sdata register, go to START; otherwise stay in IDLE.
REQ-014 START: tx_start=1 for exactly this one cycle; go to WAIT_BUSY.
REQ-015 WAIT_BUSY: on tx_busy=1 go to WAIT_DONE. After TX_BUSY_TIMEOUT cycles without tx_busy, set timeout and go to IDLE.
REQ-016 WAIT_DONE: on tx_busy=0 go to IDLE.
REQ-017 sdata SHALL hold the granted byte stable from START until leaving WAIT_DONE.
REQ-018 Minimum latency from push into an empty FIFO (arbiter idle, tx_busy=0) to tx_start=1 SHALL be 2 cycles: push edge, then IDLE grant edge.
REQ-019 Bytes from one requester SHALL be transmitted in push order, with no loss other than REQ-011/REQ-015.
REQ-020 Grant (fixed priority): boot before core whenever both are non-empty.
REQ-021 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH. Full means the MSBs differ and the rest match; empty means the pointers are equal.

Reset
REQ-022 On reset: FSM=IDLE, FIFOs empty, tx_start=0, sdata=8'h00, busy outputs=0, overflow=2'b00, timeout=0, timeout counter=0. The round-robin pointer, when present, points to boot.
REQ-023 Reset asserted mid-transfer SHALL discard the in-flight byte and all FIFO contents. No tx_start SHALL be issued until reset is released.

Configuration
REQ-024 Macro UART_TX_ARB_RR_EN. When defined, the grant is round-robin: the last-granted requester has the lowest priority next time, and the pointer updates only on a grant. When undefined, fixed priority per REQ-020 applies and no pointer register exists.

Structure
REQ-025 Package uart_arb_pkg SHALL hold the FSM state enum typedef, the requester index constants (REQ_BOOT=0, REQ_CORE=1), and the reset value of sdata. It SHALL reuse the existing w8 typedef.
REQ-026 One sub-module, tx_byte_fifo (parameter DEPTH; ports clock, reset, we, wd, re, rd, full, empty), SHALL be instantiated twice.

Verification
REQ-027 Single byte: boot pushes 8'h41 while idle; tx_busy rises 1 cycle after tx_start and stays high 20 cycles. Required: tx_start pulses exactly once, 2 cycles after the push, with sdata=8'h41; FSM back in IDLE 1 cycle after tx_busy falls.
REQ-028 Contention: boot pushes 8'hAA,8'hAB and core pushes 8'h01,8'h02 in the same cycles. Required without the macro: output order AA,AB,01,02. Required with UART_TX_ARB_RR_EN: AA,01,AB,02.
REQ-029 Overflow: core pushes 6 bytes (8'h10..8'h15) while tx_busy is held at 1 and FIFO_DEPTH=4. Required: core_busy=1 after the 4th push, overflow=2'b10, and only 10..13 are transmitted after tx_busy is released.
REQ-030 Timeout: a byte 8'h55 is granted but tx_busy is held at 0. Required: timeout=1 exactly 64 cycles after START, FSM in IDLE, and the next queued byte is then issued.
REQ-031 Reset mid-op: reset is asserted during WAIT_DONE with 3 bytes queued, then released. Required: all outputs at reset values, and no tx_start until a new push.
REQ-032 Wrap-around: 20 bytes pushed through boot at the drain rate. Required: order preserved across pointer wrap, with no spurious full or empty flags.
